// File: rtl/pressure_scan_ctrl_pkg.sv
// Shared constants and the threshold test used by the pressure analyzers.
package pressure_scan_ctrl_pkg;

    localparam int PW = 5;
    localparam logic [PW-1:0] LO_MAX_DEF = 5'd7;
    localparam logic [PW-1:0] HI_MIN_DEF = 5'd23;

    // Returns 1 when the sample lies at or beyond either limit.
    function automatic logic in_range_warn(
        input logic [PW-1:0] data,
        input logic [PW-1:0] lo,
        input logic [PW-1:0] hi
    );
        return (data <= lo) || (data >= hi);
    endfunction

endpackage

// File: rtl/pressure_scan_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping at N-1.
module pressure_scan_ctrl_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    int idx;

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        if (en) begin
            // Walk offsets from farthest to nearest so the nearest requester wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (req[idx]) begin
                    gnt_idx = IW'(idx);
                    any_gnt = 1'b1;
                end
            end
        end
        gnt = any_gnt ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/pressure_scan_ctrl.sv
// Shares one threshold evaluator across N_CH sensors; tracks persistent warnings as sticky alarms.
module pressure_scan_ctrl
    import pressure_scan_ctrl_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PERSIST = 3,
    parameter logic [PW-1:0] LO_MAX = LO_MAX_DEF,
    parameter logic [PW-1:0] HI_MIN = HI_MIN_DEF,
    localparam int CW = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_CH-1:0]    ch_valid,
    input  logic [PW*N_CH-1:0] ch_data,
    output logic [N_CH-1:0]    ch_ready,
    input  logic [N_CH-1:0]    alarm_ack,
    output logic [N_CH-1:0]    alarm,
    output logic               any_alarm,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    output logic               out_warning
);

    localparam int CNTW = 4;

    logic [N_CH-1:0] gnt;
    logic [CW-1:0]   gnt_idx;
    logic            any_gnt;
    logic [CW-1:0]   ptr_reg;

    logic            s1_valid_reg;
    logic [PW-1:0]   s1_data_reg;
    logic [CW-1:0]   s1_ch_reg;
    logic            warn;

    logic            out_valid_reg;
    logic [CW-1:0]   out_ch_reg;
    logic            out_warning_reg;
    logic [N_CH-1:0] alarm_reg;
    logic [N_CH-1:0] alarm_next;
    logic            any_alarm_reg;

    // Grants are suppressed during reset so nothing is consumed that would be dropped.
    pressure_scan_ctrl_rr_arbiter #(.N(N_CH)) u_arb (
        .req     (ch_valid),
        .ptr     (ptr_reg),
        .en      (en & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign ch_ready = gnt;
    assign warn     = in_range_warn(s1_data_reg, LO_MAX, HI_MIN);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNTW-1:0] cnt_reg;
            logic [CNTW-1:0] cnt_next;
            logic            alarm_nx;
            logic            hit;

            assign hit = s1_valid_reg && (s1_ch_reg == CW'(gi));

            // A sample for this channel takes priority over a simultaneous ack.
            always_comb begin
                cnt_next = cnt_reg;
                alarm_nx = alarm_reg[gi];
                if (hit) begin
                    if (warn) begin
                        if (cnt_reg == CNTW'(PERSIST - 1)) alarm_nx = 1'b1;
                        if (cnt_reg < CNTW'(PERSIST)) cnt_next = cnt_reg + 1'b1;
                    end else begin
                        cnt_next = '0;
                    end
                end else if (alarm_ack[gi]) begin
                    alarm_nx = 1'b0;
                    cnt_next = '0;
                end
            end

            assign alarm_next[gi] = alarm_nx;

            always_ff @(posedge clk) begin
                if (rst) cnt_reg <= '0;
                else     cnt_reg <= cnt_next;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg         <= '0;
            s1_valid_reg    <= 1'b0;
            s1_data_reg     <= '0;
            s1_ch_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_ch_reg      <= '0;
            out_warning_reg <= 1'b0;
            alarm_reg       <= '0;
            any_alarm_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= any_gnt;
            if (any_gnt) begin
                s1_data_reg <= ch_data[int'(gnt_idx)*PW +: PW];
                s1_ch_reg   <= gnt_idx;
                ptr_reg     <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_ch_reg      <= s1_ch_reg;
                out_warning_reg <= warn;
            end
            alarm_reg     <= alarm_next;
            any_alarm_reg <= |alarm_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_ch      = out_ch_reg;
    assign out_warning = out_warning_reg;
    assign alarm       = alarm_reg;
    assign any_alarm   = any_alarm_reg;

endmodule
